// File: rtl/nn_pkg.sv
// Shared types and default widths for the neural-net activation datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RELU  = 2'd1,
        LEAKY = 2'd2
    } act_mode_t;

    localparam int N_CH_DEF       = 10;
    localparam int IN_W_DEF       = 26;
    localparam int B_W_DEF        = 9;
    localparam int OUT_W_DEF      = 8;
    localparam int SHIFT_DEF      = 4;
    localparam int LEAK_SHIFT_DEF = 3;
    localparam int SAT_CNT_W      = 16;

endpackage

// File: rtl/act_lane.sv
// One neuron lane: S1 bias add register, S2 activation/requantise/saturate register.
module act_lane
    import nn_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int B_W        = B_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s1_load,
    input  logic                    s2_load,
    input  act_mode_t               mode,
    input  logic signed [IN_W-1:0]  acc,
    input  logic signed [B_W-1:0]   bias,
    output logic signed [OUT_W-1:0] y_q,
    output logic                    sat
);

    localparam int XW = IN_W + 2;
    localparam logic signed [XW-1:0] RND  = XW'((64'd1 << SHIFT) >> 1);
    localparam logic signed [XW-1:0] MAXV = XW'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [XW-1:0] MINV = -MAXV - XW'(1);

    logic signed [IN_W:0]      sum_q;
    logic signed [XW-1:0]      sum_x, y, r;
    logic signed [OUT_W-1:0]   y_d;

    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= '0;
        else if (s1_load)
            sum_q <= {acc[IN_W-1], acc} + {{(IN_W + 1 - B_W){bias[B_W-1]}}, bias};
    end

    always_comb begin
        sum_x = {sum_q[IN_W], sum_q};
        case (mode)
            RELU:    y = (sum_q > 0) ? sum_x : '0;
            LEAKY:   y = sum_q[IN_W] ? (sum_x >>> LEAK_SHIFT) : sum_x;
            default: y = sum_x;
        endcase
        // Round half up, then floor via arithmetic shift.
        r   = (y + RND) >>> SHIFT;
        sat = 1'b0;
        y_d = r[OUT_W-1:0];
        if (r > MAXV) begin
            sat = 1'b1;
            y_d = MAXV[OUT_W-1:0];
        end else if (r < MINV) begin
            sat = 1'b1;
            y_d = MINV[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            y_q <= '0;
        else if (s2_load)
            y_q <= y_d;
    end

endmodule

// File: rtl/activation_unit.sv
// Two-stage bias/activation/requantise pipeline over N_CH lanes with valid/ready flow.
// Optional saturation counter port enabled by defining ACT_SAT_COUNT_EN.
module activation_unit
    import nn_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int B_W        = B_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [N_CH*IN_W-1:0]    acc_in,
    input  logic [N_CH*B_W-1:0]     bias_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*OUT_W-1:0]   out_data
`ifdef ACT_SAT_COUNT_EN
    ,
    output logic [SAT_CNT_W-1:0]    sat_count
`endif
);

    logic [N_CH-1:0][IN_W-1:0]  acc_v;
    logic [N_CH-1:0][B_W-1:0]   bias_v;
    logic [N_CH-1:0][OUT_W-1:0] out_v;
    logic [N_CH-1:0]            sat_v;
    logic [2:1]                 vld_pipe;
    logic                       s1_load, s2_load;
    act_mode_t                  mode_q;

    assign acc_v    = acc_in;
    assign bias_v   = bias_in;
    assign out_data = out_v;

    // S2 may refill in the same cycle it drains, giving full throughput.
    assign s2_load   = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign s1_load   = !vld_pipe[1] || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            mode_q   <= NONE;
        end else begin
            if (s1_load) begin
                vld_pipe[1] <= in_valid;
                mode_q      <= act_mode_t'(mode);
            end
            if (s2_load)
                vld_pipe[2] <= 1'b1;
            else if (out_ready)
                vld_pipe[2] <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        act_lane #(
            .IN_W      (IN_W),
            .B_W       (B_W),
            .OUT_W     (OUT_W),
            .SHIFT     (SHIFT),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .s1_load(s1_load),
            .s2_load(s2_load),
            .mode   (mode_q),
            .acc    (acc_v[i]),
            .bias   (bias_v[i]),
            .y_q    (out_v[i]),
            .sat    (sat_v[i])
        );
    end

`ifdef ACT_SAT_COUNT_EN
    localparam int CNT_W = $clog2(N_CH + 1);

    logic [CNT_W-1:0]     n_sat;
    logic [SAT_CNT_W:0]   sat_sum;

    always_comb begin
        n_sat = '0;
        for (int i = 0; i < N_CH; i++)
            n_sat = n_sat + CNT_W'(sat_v[i]);
        sat_sum = {1'b0, sat_count} + (SAT_CNT_W + 1)'(n_sat);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_count <= '0;
        else if (s2_load)
            sat_count <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_v;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Randomized and directed bench for activation_unit against an arithmetic reference model.
module tb_activation_unit;

    localparam int N = 4, IW = 26, BW = 9, OW = 8, SH = 4, LS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]        mode;
    logic [N*IW-1:0]   acc_in;
    logic [N*BW-1:0]   bias_in;
    logic [N*OW-1:0]   out_data;
`ifdef ACT_SAT_COUNT_EN
    logic [15:0]       sat_count;
`endif

    activation_unit #(.N_CH(N), .IN_W(IW), .B_W(BW), .OUT_W(OW), .SHIFT(SH), .LEAK_SHIFT(LS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .acc_in   (acc_in),
        .bias_in  (bias_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef ACT_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    int checks = 0, errors = 0;
    int cycle = 0, n_acc = 0, last_lat = 0, sat_acc = 0;
    logic [N*OW-1:0] exp_q[$];
    int              sat_q[$];
    int              cyc_q[$];
    logic [OW-1:0]   out_log[$];
    logic [N*OW-1:0] last_out, held_data;
    logic            held = 1'b0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(longint a, longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: exact integer arithmetic with floor division and clamping.
    function automatic void model(input logic [N*IW-1:0] a, input logic [N*BW-1:0] b,
                                  input logic [1:0] md, output logic [N*OW-1:0] o, output int ns);
        longint lo, hi;
        lo = -(longint'(1) << (OW - 1));
        hi = (longint'(1) << (OW - 1)) - 1;
        ns = 0;
        o  = '0;
        for (int i = 0; i < N; i++) begin
            longint s, y, r;
            s = longint'($signed(a[i*IW +: IW])) + longint'($signed(b[i*BW +: BW]));
            case (md)
                2'd1:    y = (s > 0) ? s : 0;
                2'd2:    y = (s < 0) ? fdiv(s, longint'(1) << LS) : s;
                default: y = s;
            endcase
            r = fdiv(y + ((SH > 0) ? (longint'(1) << (SH - 1)) : 0), longint'(1) << SH);
            if (r > hi) begin r = hi; ns++; end
            else if (r < lo) begin r = lo; ns++; end
            o[i*OW +: OW] = r[OW-1:0];
        end
    endfunction

    task automatic tick();
        logic            in_ok, out_ok;
        logic [N*OW-1:0] e;
        int              ns;
        #1;
        in_ok  = in_valid && in_ready && !rst;
        out_ok = out_valid && out_ready && !rst;
        if (held) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(held_data));
        end
        held      = out_valid && !out_ready && !rst;
        held_data = out_data;
        if (out_ok) begin
            if (exp_q.size() == 0)
                check("unexpected_beat", 64'(out_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("data", 64'(out_data), 64'(e));
                last_lat = cycle - cyc_q.pop_front();
                sat_acc += sat_q.pop_front();
                last_out = out_data;
                out_log.push_back(out_data[OW-1:0]);
            end
        end
        if (in_ok) begin
            model(acc_in, bias_in, mode, e, ns);
            exp_q.push_back(e);
            sat_q.push_back(ns);
            cyc_q.push_back(cycle);
            n_acc++;
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete(); sat_q.delete(); cyc_q.delete();
            held = 1'b0;
            sat_acc = 0;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic set_beat(longint a, longint b, logic [1:0] md);
        for (int i = 0; i < N; i++) begin
            acc_in[i*IW +: IW]  = IW'(a);
            bias_in[i*BW +: BW] = BW'(b);
        end
        mode = md;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        tick();
`ifdef ACT_SAT_COUNT_EN
        check("sat_count", 64'(sat_count), 64'(sat_acc));
`endif
    endtask

    task automatic one_beat(longint a, longint b, logic [1:0] md, logic [OW-1:0] exp8, string tag);
        set_beat(a, b, md);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        drain();
        check(tag, 64'(last_out), 64'({N{exp8}}));
    endtask

    function automatic longint rand_acc();
        int k;
        k = $urandom_range(24, 2);
        return longint'($urandom_range((1 << (k + 1)) - 1, 0)) - (longint'(1) << k);
    endfunction

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_beat(0, 0, 2'd0);
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ACT_SAT_COUNT_EN
        check("rst_sat_count", 64'(sat_count), 64'd0);
`endif

        // Single beat: value and latency.
        one_beat(100, 20, 2'd1, 8'd8, "relu_100_20");
        check("latency", 64'(last_lat), 64'd2);
        one_beat(-100, 0, 2'd1, 8'd0, "relu_neg");
        one_beat(-100, 0, 2'd2, 8'hFF, "leaky_neg");
        one_beat(5000, 0, 2'd0, 8'd127, "sat_pos");
        one_beat(-5000, 0, 2'd0, 8'h80, "sat_neg");
`ifdef ACT_SAT_COUNT_EN
        base = sat_count;
        one_beat(5000, 0, 2'd3, 8'd127, "sat_mode3");
        check("sat_plus4", 64'(sat_count), 64'(base + 4));
`endif

        // Back-to-back beats with changing mode at full throughput.
        out_log.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int m = 0; m < 3; m++) begin
            set_beat(-64, 0, 2'(m));
            #1 check("full_tput", 64'(in_ready), 64'd1);
            tick();
        end
        drain();
        check("alt_count", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) begin
            check("alt_none", 64'(out_log[0]), 64'hFC);
            check("alt_relu", 64'(out_log[1]), 64'h00);
        end

        // Backpressure: only two beats fit.
        base = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_beat(16 * (k + 1) + 3, 0, 2'd0);
            tick();
        end
        check("bp_accepted", 64'(n_acc - base), 64'd2);
        #1 check("bp_in_ready", 64'(in_ready), 64'd0);
        drain();

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(5000, 0, 2'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ACT_SAT_COUNT_EN
        check("mid_rst_sat", 64'(sat_count), 64'd0);
`endif
        out_ready = 1'b1;
        repeat (6) tick();

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            in_valid  = ($urandom_range(99, 0) < 70);
            out_ready = ($urandom_range(99, 0) < 70);
            mode      = 2'($urandom_range(3, 0));
            for (int i = 0; i < N; i++) begin
                acc_in[i*IW +: IW]  = IW'(rand_acc());
                bias_in[i*BW +: BW] = BW'($urandom);
            end
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
